// File: rtl/variable_state_updater_pkg.sv
// Shared definitions for the variable state updater: default sizes that
// track the solver header (NUMBER_OF_BOOLEAN_VARIABLES and friends) and the
// control state encoding.
package variable_state_updater_pkg;

    // Defaults mirrored from the solver header.
    localparam int NUMBER_OF_BOOLEAN_VARIABLES         = 2;
    localparam int NUMBER_OF_INTEGER_VARIABLES         = 3;
    localparam int BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX = 8;

    localparam int DEF_NUM_BOOL = NUMBER_OF_BOOLEAN_VARIABLES;
    localparam int DEF_NUM_INT  = NUMBER_OF_INTEGER_VARIABLES;
    localparam int DEF_INDEX_W  = BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX;
    localparam int DEF_INT_W    = 8;
    localparam int DEF_INT_LO   = -100;
    localparam int DEF_INT_HI   = 100;
    localparam int DEF_MAX_ITER = 1000;

    // Width of the iteration counter.
    localparam int COUNT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE          = 3'd0,
        ST_WAIT_VAR      = 3'd1,
        ST_PROPOSE       = 3'd2,
        ST_WAIT_DECISION = 3'd3,
        ST_DONE          = 3'd4
    } state_t;

endpackage

// File: rtl/variable_state_updater_if.sv
// Handshake bundle between chooser, updater and evaluator. The slave modport
// is the updater's view; master is the surrounding pipeline's view.
interface variable_state_updater_if
    import variable_state_updater_pkg::*;
#(
    parameter int NUM_BOOL = DEF_NUM_BOOL,
    parameter int NUM_INT  = DEF_NUM_INT,
    parameter int INDEX_W  = DEF_INDEX_W,
    parameter int INT_W    = DEF_INT_W
);
    logic                        in_start;
    logic                        in_var_valid;
    logic                        in_boolean_or_integer;
    logic [INDEX_W-1:0]          in_choosen_index;
    logic signed [INT_W-1:0]     in_step;
    logic                        out_var_ready;
    logic                        out_proposal_valid;
    logic                        in_proposal_ready;
    logic                        out_proposal_is_boolean;
    logic [INDEX_W-1:0]          out_proposal_index;
    logic [INT_W-1:0]            out_proposal_old_value;
    logic [INT_W-1:0]            out_proposal_new_value;
    logic                        in_decision_valid;
    logic                        in_accept;
    logic [NUM_BOOL-1:0]         out_boolean_values;
    logic [NUM_INT*INT_W-1:0]    out_integer_values;
    logic [COUNT_W-1:0]          out_iteration_count;
    logic                        out_done;

    modport master (
        output in_start, in_var_valid, in_boolean_or_integer, in_choosen_index,
               in_step, in_proposal_ready, in_decision_valid, in_accept,
        input  out_var_ready, out_proposal_valid, out_proposal_is_boolean,
               out_proposal_index, out_proposal_old_value, out_proposal_new_value,
               out_boolean_values, out_integer_values, out_iteration_count, out_done
    );

    modport slave (
        input  in_start, in_var_valid, in_boolean_or_integer, in_choosen_index,
               in_step, in_proposal_ready, in_decision_valid, in_accept,
        output out_var_ready, out_proposal_valid, out_proposal_is_boolean,
               out_proposal_index, out_proposal_old_value, out_proposal_new_value,
               out_boolean_values, out_integer_values, out_iteration_count, out_done
    );

endinterface

// File: rtl/variable_state_updater_saturating_adder.sv
// Signed add of two INT_W operands, clamped to [INT_LO, INT_HI]. The sum is
// formed one bit wider so it can never wrap before the clamp.
module saturating_adder #(
    parameter int INT_W  = 8,
    parameter int INT_LO = -100,
    parameter int INT_HI = 100
) (
    input  logic signed [INT_W-1:0] a,
    input  logic signed [INT_W-1:0] b,
    output logic signed [INT_W-1:0] sum
);
    localparam logic signed [INT_W:0] LO_EXT = (INT_W+1)'(INT_LO);
    localparam logic signed [INT_W:0] HI_EXT = (INT_W+1)'(INT_HI);

    logic signed [INT_W:0] wide;

    // Widen, add, then clamp to the legal variable range.
    always_comb begin
        wide = {a[INT_W-1], a} + {b[INT_W-1], b};
        if (wide > HI_EXT) begin
            sum = HI_EXT[INT_W-1:0];
        end else if (wide < LO_EXT) begin
            sum = LO_EXT[INT_W-1:0];
        end else begin
            sum = wide[INT_W-1:0];
        end
    end

endmodule

// File: rtl/variable_state_updater.sv
// Holds the current boolean/integer assignment, turns each chosen variable
// into a flip or saturated-step proposal, and commits it on an accept
// decision. Counts decisions and stops after MAX_ITER of them.
module variable_state_updater
    import variable_state_updater_pkg::*;
#(
    parameter int NUM_BOOL = DEF_NUM_BOOL,
    parameter int NUM_INT  = DEF_NUM_INT,
    parameter int INDEX_W  = DEF_INDEX_W,
    parameter int INT_W    = DEF_INT_W,
    parameter int INT_LO   = DEF_INT_LO,
    parameter int INT_HI   = DEF_INT_HI,
    parameter int MAX_ITER = DEF_MAX_ITER
) (
    input  logic                   in_clock,
    input  logic                   in_reset,
    variable_state_updater_if.slave bus
);
    localparam logic [COUNT_W-1:0] MAX_COUNT   = COUNT_W'(MAX_ITER);
    localparam logic [INDEX_W-1:0] NUM_BOOL_IX = INDEX_W'(NUM_BOOL);
    localparam logic [INDEX_W-1:0] NUM_INT_IX  = INDEX_W'(NUM_INT);

    state_t                  state_reg;
    state_t                  state_next;
    logic [COUNT_W-1:0]      count_reg;
    logic                    prop_is_bool_reg;
    logic [INDEX_W-1:0]      prop_index_reg;
    logic [INT_W-1:0]        prop_old_reg;
    logic [INT_W-1:0]        prop_new_reg;

    logic [NUM_BOOL-1:0]     bool_values;
    logic signed [INT_W-1:0] int_values [NUM_INT];

    logic                    start_fire;
    logic                    capture_fire;
    logic                    index_ok;
    logic                    capture_ok;
    logic                    decision_fire;
    logic                    commit_fire;
    logic                    last_iter;
    logic                    bool_sel;
    logic signed [INT_W-1:0] int_sel;
    logic signed [INT_W-1:0] int_sum;
    logic [INT_W-1:0]        cand_old;
    logic [INT_W-1:0]        cand_new;

    assign start_fire    = ((state_reg == ST_IDLE) || (state_reg == ST_DONE)) && bus.in_start;
    assign capture_fire  = (state_reg == ST_WAIT_VAR) && bus.in_var_valid;
    assign index_ok      = bus.in_boolean_or_integer ? (bus.in_choosen_index < NUM_BOOL_IX)
                                                     : (bus.in_choosen_index < NUM_INT_IX);
    assign capture_ok    = capture_fire && index_ok;
    assign decision_fire = (state_reg == ST_WAIT_DECISION) && bus.in_decision_valid;
    assign commit_fire   = decision_fire && bus.in_accept;
    assign last_iter     = (count_reg + COUNT_W'(1)) == MAX_COUNT;

    // Look up the current value of the chosen variable; out-of-range indices read 0.
    always_comb begin
        bool_sel = 1'b0;
        int_sel  = '0;
        for (int k = 0; k < NUM_BOOL; k++) begin
            if (bus.in_choosen_index == INDEX_W'(k)) begin
                bool_sel = bool_values[k];
            end
        end
        for (int k = 0; k < NUM_INT; k++) begin
            if (bus.in_choosen_index == INDEX_W'(k)) begin
                int_sel = int_values[k];
            end
        end
    end

    saturating_adder #(
        .INT_W  (INT_W),
        .INT_LO (INT_LO),
        .INT_HI (INT_HI)
    ) u_saturating_adder (
        .a   (int_sel),
        .b   (bus.in_step),
        .sum (int_sum)
    );

    // Candidate proposal: booleans flip and are zero-extended, integers step.
    always_comb begin
        cand_old = int_sel;
        cand_new = int_sum;
        if (bus.in_boolean_or_integer) begin
            cand_old = {{(INT_W-1){1'b0}}, bool_sel};
            cand_new = {{(INT_W-1){1'b0}}, ~bool_sel};
        end
    end

    // Control state register.
    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; strobes arriving in the wrong state fall through unchanged.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:          if (start_fire) state_next = ST_WAIT_VAR;
            ST_WAIT_VAR:      if (capture_ok) state_next = ST_PROPOSE;
            ST_PROPOSE:       if (bus.in_proposal_ready) state_next = ST_WAIT_DECISION;
            ST_WAIT_DECISION: if (decision_fire) state_next = last_iter ? ST_DONE : ST_WAIT_VAR;
            ST_DONE:          if (start_fire) state_next = ST_WAIT_VAR;
            default:          state_next = ST_IDLE;
        endcase
    end

    // Decision counter: cleared on each run start, bumped on every decision.
    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            count_reg <= '0;
        end else if (start_fire) begin
            count_reg <= '0;
        end else if (decision_fire) begin
            count_reg <= count_reg + COUNT_W'(1);
        end
    end

    // Latch the proposal at capture and hold it until the next capture.
    always_ff @(posedge in_clock or negedge in_reset) begin
        if (!in_reset) begin
            prop_is_bool_reg <= 1'b0;
            prop_index_reg   <= '0;
            prop_old_reg     <= '0;
            prop_new_reg     <= '0;
        end else if (capture_ok) begin
            prop_is_bool_reg <= bus.in_boolean_or_integer;
            prop_index_reg   <= bus.in_choosen_index;
            prop_old_reg     <= cand_old;
            prop_new_reg     <= cand_new;
        end
    end

    // One storage register per boolean variable, written only on a matching commit.
    for (genvar gi = 0; gi < NUM_BOOL; gi++) begin : g_bool
        logic value_reg;

        // Commit the flipped bit when the accepted proposal targets this variable.
        always_ff @(posedge in_clock or negedge in_reset) begin
            if (!in_reset) begin
                value_reg <= 1'b0;
            end else if (commit_fire && prop_is_bool_reg && (prop_index_reg == INDEX_W'(gi))) begin
                value_reg <= prop_new_reg[0];
            end
        end

        assign bool_values[gi] = value_reg;
    end

    // One storage register per integer variable, written only on a matching commit.
    for (genvar gi = 0; gi < NUM_INT; gi++) begin : g_int
        logic signed [INT_W-1:0] value_reg;

        // Commit the stepped value when the accepted proposal targets this variable.
        always_ff @(posedge in_clock or negedge in_reset) begin
            if (!in_reset) begin
                value_reg <= '0;
            end else if (commit_fire && !prop_is_bool_reg && (prop_index_reg == INDEX_W'(gi))) begin
                value_reg <= prop_new_reg;
            end
        end

        assign int_values[gi] = value_reg;
        assign bus.out_integer_values[gi*INT_W +: INT_W] = value_reg;
    end

    assign bus.out_var_ready           = (state_reg == ST_WAIT_VAR);
    assign bus.out_proposal_valid      = (state_reg == ST_PROPOSE);
    assign bus.out_done                = (state_reg == ST_DONE);
    assign bus.out_proposal_is_boolean = prop_is_bool_reg;
    assign bus.out_proposal_index      = prop_index_reg;
    assign bus.out_proposal_old_value  = prop_old_reg;
    assign bus.out_proposal_new_value  = prop_new_reg;
    assign bus.out_boolean_values      = bool_values;
    assign bus.out_iteration_count     = count_reg;

endmodule

// File: tb/tb_variable_state_updater.sv
// Bench for variable_state_updater: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model of the assignment, proposal and run counter.
module tb_variable_state_updater;

    localparam int NB   = 2;
    localparam int NI   = 3;
    localparam int IW   = 8;
    localparam int W    = 8;
    localparam int LO   = -100;
    localparam int HI   = 100;
    localparam int MAXI = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    variable_state_updater_if #(.NUM_BOOL(NB), .NUM_INT(NI), .INDEX_W(IW), .INT_W(W)) bus ();

    variable_state_updater #(
        .NUM_BOOL (NB),
        .NUM_INT  (NI),
        .INDEX_W  (IW),
        .INT_W    (W),
        .INT_LO   (LO),
        .INT_HI   (HI),
        .MAX_ITER (MAXI)
    ) dut (
        .in_clock (clk),
        .in_reset (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Phase: 0 idle, 1 waiting for a variable, 2 offering a proposal,
    // 3 waiting for the decision, 4 run finished.
    int m_phase  = 0;
    int m_count  = 0;
    int m_bool [NB];
    int m_int  [NI];
    int m_p_bool = 0;
    int m_p_idx  = 0;
    int m_p_old  = 0;
    int m_p_new  = 0;

    function automatic int clamp(input int v);
        if (v > HI) return HI;
        if (v < LO) return LO;
        return v;
    endfunction

    initial begin
        for (int k = 0; k < NB; k++) m_bool[k] = 0;
        for (int k = 0; k < NI; k++) m_int[k] = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_phase = 0; m_count = 0;
                m_p_bool = 0; m_p_idx = 0; m_p_old = 0; m_p_new = 0;
                for (int k = 0; k < NB; k++) m_bool[k] = 0;
                for (int k = 0; k < NI; k++) m_int[k] = 0;
            end else begin
                int idx;
                int stp;
                idx = int'(bus.in_choosen_index);
                stp = int'(bus.in_step);
                case (m_phase)
                    0, 4: begin
                        if (bus.in_start) begin
                            m_phase = 1;
                            m_count = 0;
                        end
                    end
                    1: begin
                        if (bus.in_var_valid) begin
                            if (bus.in_boolean_or_integer && idx < NB) begin
                                m_p_bool = 1; m_p_idx = idx;
                                m_p_old = m_bool[idx]; m_p_new = 1 - m_bool[idx];
                                m_phase = 2;
                            end else if (!bus.in_boolean_or_integer && idx < NI) begin
                                m_p_bool = 0; m_p_idx = idx;
                                m_p_old = m_int[idx]; m_p_new = clamp(m_int[idx] + stp);
                                m_phase = 2;
                            end
                        end
                    end
                    2: if (bus.in_proposal_ready) m_phase = 3;
                    3: begin
                        if (bus.in_decision_valid) begin
                            if (bus.in_accept) begin
                                if (m_p_bool != 0) m_bool[m_p_idx] = m_p_new;
                                else m_int[m_p_idx] = m_p_new;
                            end
                            m_count = m_count + 1;
                            m_phase = (m_count == MAXI) ? 4 : 1;
                        end
                    end
                    default: m_phase = 0;
                endcase
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic int dut_int(input int k);
        logic signed [W-1:0] v;
        v = bus.out_integer_values[k*W +: W];
        return int'(v);
    endfunction

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                check("cyc_ready", bus.out_var_ready, (m_phase == 1));
                check("cyc_pvalid", bus.out_proposal_valid, (m_phase == 2));
                check("cyc_done", bus.out_done, (m_phase == 4));
                check("cyc_count", bus.out_iteration_count, m_count);
                for (int k = 0; k < NB; k++) check("cyc_bool", bus.out_boolean_values[k], m_bool[k]);
                for (int k = 0; k < NI; k++) check("cyc_int", dut_int(k), m_int[k]);
                if (m_phase == 2) begin
                    logic signed [W-1:0] po;
                    logic signed [W-1:0] pn;
                    po = bus.out_proposal_old_value;
                    pn = bus.out_proposal_new_value;
                    check("cyc_p_isbool", bus.out_proposal_is_boolean, m_p_bool);
                    check("cyc_p_idx", bus.out_proposal_index, m_p_idx);
                    check("cyc_p_old", int'(po), m_p_old);
                    check("cyc_p_new", int'(pn), m_p_new);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_start = 0; bus.in_var_valid = 0; bus.in_boolean_or_integer = 0;
        bus.in_choosen_index = '0; bus.in_step = '0; bus.in_proposal_ready = 0;
        bus.in_decision_valid = 0; bus.in_accept = 0;
    endtask

    // Offer one variable, take the proposal the next cycle, decide the cycle after.
    task automatic do_move(input logic isb, input int idx, input int stp, input logic acc,
                           output logic [W-1:0] p_old, output logic [W-1:0] p_new);
        bus.in_var_valid = 1; bus.in_boolean_or_integer = isb;
        bus.in_choosen_index = idx[IW-1:0]; bus.in_step = stp[W-1:0];
        tick();
        bus.in_var_valid = 0;
        check("mv_pvalid", bus.out_proposal_valid, 1);
        p_old = bus.out_proposal_old_value;
        p_new = bus.out_proposal_new_value;
        bus.in_proposal_ready = 1;
        tick();
        bus.in_proposal_ready = 0;
        check("mv_pvalid_drop", bus.out_proposal_valid, 0);
        bus.in_decision_valid = 1; bus.in_accept = acc;
        tick();
        bus.in_decision_valid = 0; bus.in_accept = 0;
    endtask

    initial begin
        logic [W-1:0] po;
        logic [W-1:0] pn;
        idle_inputs();
        rst_n = 0;
        tick(); tick(); tick();
        cmp_en = 1;
        check("rst_ready", bus.out_var_ready, 0);
        check("rst_count", bus.out_iteration_count, 0);
        check("rst_ints", bus.out_integer_values, 0);
        rst_n = 1;
        tick();

        // Run 1: boolean flip, integer build-up, saturated reject reaching MAX_ITER.
        bus.in_start = 1; tick(); bus.in_start = 0;
        check("start_ready", bus.out_var_ready, 1);
        do_move(1'b1, 1, 0, 1'b1, po, pn);
        check("b1_old", po, 0);
        check("b1_new", pn, 1);
        check("b1_bools", bus.out_boolean_values, 2'b10);
        check("b1_count", bus.out_iteration_count, 1);
        do_move(1'b0, 2, 95, 1'b1, po, pn);
        check("i2_new95", pn, 95);
        do_move(1'b0, 2, 20, 1'b0, po, pn);
        check("sat_old", po, 95);
        check("sat_new", pn, 100);
        check("sat_keep", bus.out_integer_values[2*W +: W], 95);
        check("sat_count", bus.out_iteration_count, 3);
        check("done_flag", bus.out_done, 1);
        check("done_ready", bus.out_var_ready, 0);

        // Run 2: restart, negative clamp, out-of-range drop, proposal stall.
        bus.in_start = 1; tick(); bus.in_start = 0;
        check("restart_count", bus.out_iteration_count, 0);
        check("restart_done", bus.out_done, 0);
        check("restart_ready", bus.out_var_ready, 1);
        do_move(1'b0, 0, -128, 1'b1, po, pn);
        check("lo_new", pn, 8'h9C);
        check("lo_val", bus.out_integer_values[7:0], 8'h9C);

        bus.in_var_valid = 1; bus.in_boolean_or_integer = 1; bus.in_choosen_index = 8'd5;
        tick();
        bus.in_var_valid = 0;
        check("oor_pvalid", bus.out_proposal_valid, 0);
        check("oor_ready", bus.out_var_ready, 1);
        check("oor_count", bus.out_iteration_count, 1);

        bus.in_var_valid = 1; bus.in_boolean_or_integer = 0; bus.in_choosen_index = 8'd1;
        bus.in_step = 8'sd3;
        tick();
        bus.in_var_valid = 0;
        for (int i = 0; i < 4; i++) begin
            bus.in_decision_valid = 1; bus.in_accept = 1;
            tick();
            check("stall_pvalid", bus.out_proposal_valid, 1);
            check("stall_new", bus.out_proposal_new_value, 3);
            check("stall_ready", bus.out_var_ready, 0);
        end
        bus.in_decision_valid = 0; bus.in_accept = 0;
        bus.in_proposal_ready = 1; tick(); bus.in_proposal_ready = 0;
        bus.in_decision_valid = 1; bus.in_accept = 1; tick();
        bus.in_decision_valid = 0; bus.in_accept = 0;
        check("stall_commit", bus.out_integer_values[15:8], 3);
        check("stall_count", bus.out_iteration_count, 2);

        // Reset while waiting for a decision.
        bus.in_var_valid = 1; bus.in_boolean_or_integer = 1; bus.in_choosen_index = 8'd0;
        tick();
        bus.in_var_valid = 0; bus.in_proposal_ready = 1;
        tick();
        bus.in_proposal_ready = 0; bus.in_decision_valid = 1; bus.in_accept = 1;
        rst_n = 0;
        #1;
        check("midrst_ints", bus.out_integer_values, 0);
        check("midrst_bools", bus.out_boolean_values, 0);
        check("midrst_count", bus.out_iteration_count, 0);
        tick();
        idle_inputs();
        rst_n = 1;
        tick();
        check("midrst_idle", bus.out_var_ready, 0);

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            logic isb;
            int idx;
            isb = 1'($urandom_range(0, 1));
            idx = isb ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 4));
            if ($urandom_range(0, 15) == 0) idx = int'($urandom_range(0, 255));
            bus.in_var_valid          = ($urandom_range(0, 2) != 0);
            bus.in_boolean_or_integer = isb;
            bus.in_choosen_index      = idx[IW-1:0];
            bus.in_step               = W'($urandom);
            bus.in_proposal_ready     = 1'($urandom_range(0, 1));
            bus.in_decision_valid     = 1'($urandom_range(0, 1));
            bus.in_accept             = 1'($urandom_range(0, 1));
            bus.in_start              = ($urandom_range(0, 7) == 0);
            rst_n                     = ($urandom_range(0, 499) != 0);
            tick();
        end
        idle_inputs();
        rst_n = 1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/variable_state_updater.md
Name: variable_state_updater

Overview:
- Stage directly downstream of VariableChooser; consumes each chosen (type, index) pair plus a signed random step.
- Holds the current assignment of all boolean and integer variables.
- Boolean proposal flips the bit; integer proposal adds the step, saturated to the variable range. The proposal goes to the cost/acceptance stage, and the block commits or discards it on that stage's decision.
- Counts MCMC iterations and drives the chooser enable so a new variable is drawn only when this block can take it.

Parameters:
- NUM_BOOL, 2, number of boolean variables (matches NUMBER_OF_BOOLEAN_VARIABLES).
- NUM_INT, 3, number of integer variables (matches NUMBER_OF_INTEGER_VARIABLES).
- INDEX_W, 8, index width (matches BIT_WIDTH_OF_INTEGER_VARIABLE_INDEX).
- INT_W, 8, signed integer variable width.
- INT_LO, -100, lowest legal integer value; must be <= 0.
- INT_HI, 100, highest legal integer value; must be >= 0.
- MAX_ITER, 1000, decisions per run; 16-bit counter.

Ports:
- in_clock  in  1  system clock, rising edge.
- in_reset  in  1  asynchronous, active-low reset (0 = reset).
- in_start  in  1  one-cycle pulse that starts a run from IDLE or DONE.
- in_var_valid  in  1  chooser output valid.
- in_boolean_or_integer  in  1  1 = boolean, 0 = integer.
- in_choosen_index  in  INDEX_W  variable index within its type.
- in_step  in  INT_W  signed random step for integer proposals.
- out_var_ready  out  1  chooser enable; capture occurs when valid && ready.
- out_proposal_valid  out  1  proposal available.
- in_proposal_ready  in  1  evaluator accepts the proposal.
- out_proposal_is_boolean  out  1  type of the proposed variable.
- out_proposal_index  out  INDEX_W  index of the proposed variable.
- out_proposal_old_value  out  INT_W  current value; booleans zero-extended.
- out_proposal_new_value  out  INT_W  proposed value; booleans zero-extended.
- in_decision_valid  in  1  decision strobe.
- in_accept  in  1  1 = commit the proposal, 0 = reject it.
- out_boolean_values  out  NUM_BOOL  current boolean assignment.
- out_integer_values  out  NUM_INT*INT_W  current integer assignment; variable k at bits [k*INT_W +: INT_W].
- out_iteration_count  out  16  decisions taken in the current run.
- out_done  out  1  run complete.

Behaviour:
- Reset (in_reset=0, asynchronous):
  - state=IDLE.
  - All outputs 0 and all variable values 0.
  - Latched proposal cleared.
- FSM states: IDLE, WAIT_VAR, PROPOSE, WAIT_DECISION, DONE.
- IDLE: out_var_ready=0. in_start -> WAIT_VAR; iteration count cleared.
- WAIT_VAR: out_var_ready=1. On in_var_valid:
  - Capture type, index and step.
  - Out-of-range index (boolean index >= NUM_BOOL, or integer index >= NUM_INT): drop it and stay in WAIT_VAR. No count change.
  - Otherwise register the proposal and go to PROPOSE. out_proposal_valid rises the cycle after capture (latency 1).
- Proposal arithmetic:
  - Boolean: new = ~old.
  - Integer: sum = old + step, sign-extended to INT_W+1 bits, then clamped to [INT_LO, INT_HI].
  - step=0 still produces a proposal with new=old.
- PROPOSE:
  - out_proposal_valid=1; all proposal outputs held stable until in_proposal_ready=1.
  - That cycle -> WAIT_DECISION; valid drops the next cycle.
- WAIT_DECISION: on in_decision_valid:
  - If in_accept=1, write the new value; it is visible on the value outputs the next cycle.
  - Count increments in both cases.
  - If the new count == MAX_ITER -> DONE, else -> WAIT_VAR.
- DONE: out_done=1 and out_var_ready=0; values retained. in_start clears the count, drops out_done and goes to WAIT_VAR.
- Ignored inputs:
  - in_decision_valid outside WAIT_DECISION.
  - in_var_valid outside WAIT_VAR.
  - in_start outside IDLE/DONE.
- Simultaneous strobes: in_var_valid in the same cycle as a decision is not captured (ready=0 in WAIT_DECISION).
- Reset mid-run: any state returns to IDLE immediately; assignment and count cleared; no partial commit.

Decomposition:
- Shared package/header holds the state encoding and NUM_BOOL/NUM_INT/INDEX_W/INT_W defaults, tied to the existing header defines.
- One sub-module, saturating_adder: combinational signed add with clamp to [INT_LO, INT_HI], reused by later integer-move stages.

Test Plan:
- Reset, in_start, then chooser gives bool idx 1; proposal ready and decision given in the cycle after each valid; accept=1 -> proposal old=0, new=1 one cycle after capture; out_boolean_values=2'b10; count=1.
- Int idx 2 with value 95, step +20, INT_HI=100 -> new=100 (saturated); reject -> value stays 95; count still increments.
- Int idx 0 with value 0, step -128 -> new=-100 (clamped to INT_LO); accept -> bits [7:0] = 8'h9C.
- Bool idx 5 (out of range) -> no out_proposal_valid, remain in WAIT_VAR with ready=1, count unchanged.
- in_proposal_ready held 0 for 4 cycles -> proposal outputs stable, out_var_ready=0; decision strobes during PROPOSE ignored.
- MAX_ITER=3: three decisions -> out_done=1, ready=0; in_start -> count=0, WAIT_VAR. Reset mid-WAIT_DECISION -> IDLE, all values 0.
